// File: rtl/mips_ctrl_fsm.sv
// mips_ctrl_fsm -- multi-cycle control FSM for a MIPS-style core.
//
// Sequences one instruction at a time through IDLE -> DECODE -> EXEC ->
// [MEM_WAIT] -> WB. It decodes the opcode into ALU controls, waits for the
// data memory on LW/SW (with a timeout), and reports per-instruction status.
// All outputs are registered.
//
// Parameters:
//   MEM_TIMEOUT    maximum MEM_WAIT cycles before a memory request is aborted
// Ports:
//   clk, reset           clock; asynchronous active-high reset
//   instr_valid, instr   instruction offer (accepted when instr_ready is 1)
//   instr_ready          high only in IDLE
//   alu_func, alu_shamt, alu_src_b_imm   ALU controls, valid EXEC..WB
//   alu_zero             ALU zero flag, sampled in EXEC
//   mem_read, mem_write  data-memory request, held in MEM_WAIT
//   mem_ack              data-memory completion (only observed in MEM_WAIT)
//   reg_write, branch_taken, done   WB-cycle status
//   illegal              pulse on bad opcode (in DECODE) or memory timeout
//   retired_count        retired-instruction counter
// Build option:
//   CTRL_PERF_CNT_EN     when defined, retired_count counts WB cycles;
//                        otherwise it is tied to 0.
module mips_ctrl_fsm #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  input  logic [31:0] instr,
  output logic        instr_ready,
  output logic [5:0]  alu_func,
  output logic [4:0]  alu_shamt,
  output logic        alu_src_b_imm,
  input  logic        alu_zero,
  output logic        mem_read,
  output logic        mem_write,
  input  logic        mem_ack,
  output logic        reg_write,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal,
  output logic [31:0] retired_count
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_DECODE, S_EXEC, S_MEM_WAIT, S_WB} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             instr_ready_q, instr_ready_d;
  logic [5:0]       alu_func_q, alu_func_d;
  logic [4:0]       alu_shamt_q, alu_shamt_d;
  logic             alu_imm_q, alu_imm_d;
  logic             mem_read_q, mem_read_d;
  logic             mem_write_q, mem_write_d;
  logic             reg_write_q, reg_write_d;
  logic             branch_q, branch_d;
  logic             done_q, done_d;
  logic             illegal_q, illegal_d;

  // Only opcode, shamt and funct matter to control; the rest is datapath.
  logic [5:0] opcode_q, funct_q;
  logic [4:0] shamt_q;
  logic       unused_instr_bits;
  assign unused_instr_bits = ^instr[25:11];

  logic accept;
  assign accept = (state_q == S_IDLE) && instr_valid;

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      6'b000000, 6'b001000, 6'b001001, 6'b001100, 6'b001101, 6'b001110,
      6'b001010, 6'b001011, 6'b000100, 6'b000101, 6'b100011, 6'b101011:
        op_legal = 1'b1;
      default: op_legal = 1'b0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (accept) begin
      opcode_q <= instr[31:26];
      shamt_q  <= instr[10:6];
      funct_q  <= instr[5:0];
    end
  end

  // Decode of the latched instruction.
  logic [5:0] dec_func;
  logic [4:0] dec_shamt;
  logic       dec_imm, is_r, is_alui, is_beq, is_bne, is_lw, is_sw;

  always_comb begin
    dec_func  = '0;
    dec_shamt = '0;
    dec_imm   = 1'b0;
    is_r      = 1'b0;
    is_alui   = 1'b0;
    is_beq    = 1'b0;
    is_bne    = 1'b0;
    is_lw     = 1'b0;
    is_sw     = 1'b0;
    case (opcode_q)
      6'b000000: begin dec_func = funct_q; dec_shamt = shamt_q; is_r = 1'b1; end
      6'b001000: begin dec_func = 6'b100000; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b001001: begin dec_func = 6'b100001; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b001100: begin dec_func = 6'b100100; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b001101: begin dec_func = 6'b100101; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b001110: begin dec_func = 6'b100110; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b001010: begin dec_func = 6'b101010; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b001011: begin dec_func = 6'b101011; dec_imm = 1'b1; is_alui = 1'b1; end
      6'b000100: begin dec_func = 6'b100010; is_beq = 1'b1; end
      6'b000101: begin dec_func = 6'b100010; is_bne = 1'b1; end
      6'b100011: begin dec_func = 6'b100001; dec_imm = 1'b1; is_lw = 1'b1; end
      6'b101011: begin dec_func = 6'b100001; dec_imm = 1'b1; is_sw = 1'b1; end
      default: ;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    illegal_d = 1'b0;
    branch_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (instr_valid) begin
          state_d   = S_DECODE;
          // Illegal pulse is registered at accept so it is visible in DECODE.
          illegal_d = !op_legal(instr[31:26]);
        end
      end
      S_DECODE: state_d = op_legal(opcode_q) ? S_EXEC : S_IDLE;
      S_EXEC: begin
        state_d  = (is_lw || is_sw) ? S_MEM_WAIT : S_WB;
        cnt_d    = '0;
        branch_d = (is_beq && alu_zero) || (is_bne && !alu_zero);
      end
      S_MEM_WAIT: begin
        // mem_ack has priority over the timeout on the final cycle.
        if (mem_ack) begin
          state_d = S_WB;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_IDLE;
          illegal_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    instr_ready_d = (state_d == S_IDLE);
    mem_read_d    = (state_d == S_MEM_WAIT) && is_lw;
    mem_write_d   = (state_d == S_MEM_WAIT) && is_sw;
    done_d        = (state_d == S_WB);
    reg_write_d   = (state_d == S_WB) && (is_r || is_alui || is_lw);

    // ALU controls load leaving DECODE, clear in IDLE/DECODE, hold otherwise.
    if (state_q == S_DECODE && state_d == S_EXEC) begin
      alu_func_d  = dec_func;
      alu_shamt_d = dec_shamt;
      alu_imm_d   = dec_imm;
    end else if (state_d == S_IDLE || state_d == S_DECODE) begin
      alu_func_d  = '0;
      alu_shamt_d = '0;
      alu_imm_d   = 1'b0;
    end else begin
      alu_func_d  = alu_func_q;
      alu_shamt_d = alu_shamt_q;
      alu_imm_d   = alu_imm_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      instr_ready_q <= 1'b1;
      alu_func_q    <= '0;
      alu_shamt_q   <= '0;
      alu_imm_q     <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      reg_write_q   <= 1'b0;
      branch_q      <= 1'b0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      instr_ready_q <= instr_ready_d;
      alu_func_q    <= alu_func_d;
      alu_shamt_q   <= alu_shamt_d;
      alu_imm_q     <= alu_imm_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      reg_write_q   <= reg_write_d;
      branch_q      <= branch_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
    end
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] retired_q, retired_d;

  always_comb begin
    retired_d = retired_q + ((state_q == S_WB) ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign retired_count = retired_q;
`else
  assign retired_count = '0;
`endif

  assign instr_ready   = instr_ready_q;
  assign alu_func      = alu_func_q;
  assign alu_shamt     = alu_shamt_q;
  assign alu_src_b_imm = alu_imm_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign reg_write     = reg_write_q;
  assign branch_taken  = branch_q;
  assign done          = done_q;
  assign illegal       = illegal_q;

endmodule
